mem_sram_ctrl: RTL and testbench

MEM_SRAM_CTRL -- requirements
Module: mem_sram_ctrl

---
 rtl/arm_mem_pkg.sv | 16 +
 rtl/mem_sram_ctrl.sv | 133 +++++++++++++
 tb/tb_mem_sram_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/arm_mem_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: FSM state encoding,
// external SRAM geometry and the default base address of the SRAM window.
package arm_mem_pkg;

  localparam int unsigned SRAM_AW = 18;
  localparam int unsigned SRAM_DW = 16;
  localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mem_sram_ctrl.sv
// MEM-stage controller that splits each 32-bit load/store into two 16-bit
// SRAM half-word accesses and stalls the pipeline via ready until done.
//
// state | meaning
// IDLE  | waiting; a request here is latched and ready drops
// LO    | half-word 0 (bits 15:0); first cycle is address setup
// HI    | half-word 1 (bits 31:16); first cycle is address setup
// DONE  | access complete, ready high for one cycle
module mem_sram_ctrl
  import arm_mem_pkg::*;
#(
  parameter int unsigned HALF_WAIT = 3,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic               SRAM_WE_N
);

  localparam int unsigned CNT_W = (HALF_WAIT > 1) ? $clog2(HALF_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_WAIT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_wr_q, is_wr_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [SRAM_DW-1:0] rd_lo_q, rd_lo_d;

  logic               cnt_last;
  logic               in_access;
  logic               half_sel;
  logic               dq_oe;
  logic [SRAM_DW-1:0] dq_out;
  logic [31:0]        offs;
  logic               unused_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_lo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rd_lo_q <= rd_lo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_wr_d  = is_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rd_lo_d  = rd_lo_q;
    cnt_last = (cnt_q == CNT_LAST);
    case (state_q)
      ST_IDLE: begin
        if (rd_en || wr_en) begin
          addr_d  = address;
          wdata_d = write_data;
          is_wr_d = wr_en;
          cnt_d   = '0;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = ST_HI;
          if (!is_wr_q) rd_lo_d = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HI: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = ST_DONE;
          // read_data only changes as a whole word, so it stays stable until the next read finishes
          if (!is_wr_q) rdata_d = {SRAM_DQ, rd_lo_q};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ready = (state_q == ST_DONE) ||
                 ((state_q == ST_IDLE) && !(rd_en || wr_en));

  assign in_access = (state_q == ST_LO) || (state_q == ST_HI);
  assign half_sel  = (state_q == ST_HI);
  assign offs      = addr_q - BASE_ADDR;
  assign SRAM_ADDR = {offs[SRAM_AW:2], half_sel};

  // the first cycle of each half is address setup, so the strobe waits one cycle
  assign SRAM_WE_N = !(is_wr_q && in_access && (cnt_q != '0));
  assign dq_oe     = is_wr_q && in_access;
  assign dq_out    = half_sel ? wdata_q[31:16] : wdata_q[15:0];
  assign SRAM_DQ   = dq_oe ? dq_out : {SRAM_DW{1'bz}};

  assign read_data = rdata_q;
  assign unused_ok = ^{offs[31:SRAM_AW+1], offs[1:0]};

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl: behavioural SRAM, reference memory model
// and a scoreboard queue of expected load words.
module tb_mem_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic        SRAM_WE_N;

  logic [15:0] mem   [0:63];
  logic [15:0] model [0:63];
  logic        tb_drive;
  logic [31:0] exp_q [$];

  int n_assert = 0;
  int n_fail   = 0;

  mem_sram_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_ADDR  (SRAM_ADDR),
    .SRAM_DQ    (SRAM_DQ),
    .SRAM_WE_N  (SRAM_WE_N)
  );

  always #5 clk = ~clk;

  assign SRAM_DQ = tb_drive ? mem[SRAM_ADDR[5:0]] : 16'bz;

  always @(posedge clk) begin
    if (!SRAM_WE_N) mem[SRAM_ADDR[5:0]] <= SRAM_DQ;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one access starting just after a rising edge; returns just after the
  // edge that leaves DONE. drop_at>0 removes the request (and scrambles the
  // inputs) after that many ready-low cycles; hold keeps the request up at DONE.
  task automatic access(input string tag, input logic wr, input logic rd,
                        input logic [31:0] addr, input logic [31:0] data,
                        input int drop_at, input logic hold);
    int   low    = 0;
    int   we_low = 0;
    int   pulses = 0;
    int   w;
    logic prev_we = 1'b1;
    bit   done    = 1'b0;
    rd_en      = rd;
    wr_en      = wr;
    address    = addr;
    write_data = data;
    tb_drive   = rd && !wr;
    w = int'((addr - 32'd1024) >> 2) * 2 % 64;
    if (wr) begin
      model[w]     = data[15:0];
      model[w + 1] = data[31:16];
    end else begin
      exp_q.push_back({model[w + 1], model[w]});
    end
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (ready) begin
        done = 1'b1;
      end else begin
        low++;
        if (!SRAM_WE_N) begin
          we_low++;
          if (prev_we) pulses++;
        end
        prev_we = SRAM_WE_N;
        @(posedge clk);
        #1;
        if (low == drop_at) begin
          rd_en      = 1'b0;
          wr_en      = 1'b0;
          address    = 32'hFFFF_FFF0;
          write_data = 32'h0;
        end
      end
    end
    check({tag, " reached_done"}, 32'(done), 32'd1);
    check({tag, " ready_low_cycles"}, low, 32'd7);
    check({tag, " we_low_cycles"}, we_low, wr ? 32'd4 : 32'd0);
    check({tag, " we_pulses"}, pulses, wr ? 32'd2 : 32'd0);
    if (!wr) begin
      if (exp_q.size() > 0) check({tag, " read_data"}, read_data, exp_q.pop_front());
      else check({tag, " scoreboard_empty"}, 32'd0, 32'd1);
    end
    if (!hold) begin
      rd_en = 1'b0;
      wr_en = 1'b0;
    end
    @(posedge clk);
    #1;
    tb_drive = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]   = 16'h0000;
      model[i] = 16'h0000;
    end
    tb_drive   = 1'b0;
    rst        = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    address    = 32'h0;
    write_data = 32'h0;

    #12;
    check("reset ready", 32'(ready), 32'd1);
    check("reset we_n", 32'(SRAM_WE_N), 32'd1);
    check("reset read_data", read_data, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    access("wr1024", 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 0, 1'b0);
    check("wr1024 sram0", 32'(mem[0]), 32'h0000_BEEF);
    check("wr1024 sram1", 32'(mem[1]), 32'h0000_DEAD);

    access("rd1024", 1'b0, 1'b1, 32'd1024, 32'h0, 0, 1'b0);
    check("rd1024 word", read_data, 32'hDEADBEEF);

    access("rdwr1028", 1'b1, 1'b1, 32'd1028, 32'h12345678, 0, 1'b0);
    check("rdwr1028 sram2", 32'(mem[2]), 32'h0000_5678);
    check("rdwr1028 sram3", 32'(mem[3]), 32'h0000_1234);
    check("rdwr1028 read_data kept", read_data, 32'hDEADBEEF);

    access("b2b1032", 1'b1, 1'b0, 32'd1032, 32'hA1A2A3A4, 0, 1'b1);
    access("b2b1036", 1'b1, 1'b0, 32'd1036, 32'hB1B2B3B4, 0, 1'b0);
    check("b2b sram4", 32'(mem[4]), 32'h0000_A3A4);
    check("b2b sram5", 32'(mem[5]), 32'h0000_A1A2);
    check("b2b sram6", 32'(mem[6]), 32'h0000_B3B4);
    check("b2b sram7", 32'(mem[7]), 32'h0000_B1B2);

    access("rddrop1036", 1'b0, 1'b1, 32'd1036, 32'h0, 2, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("idle ready", 32'(ready), 32'd1);
    check("read_data stable", read_data, 32'hB1B2B3B4);

    wr_en      = 1'b1;
    address    = 32'd1040;
    write_data = 32'hCAFEF00D;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("abort we_low hi2", 32'(SRAM_WE_N), 32'd0);
    check("abort addr hi", 32'(SRAM_ADDR), 32'd9);
    check("abort ready", 32'(ready), 32'd0);
    rst   = 1'b0;
    wr_en = 1'b0;
    #1;
    check("abort we_n", 32'(SRAM_WE_N), 32'd1);
    check("abort ready in rst", 32'(ready), 32'd1);
    check("abort read_data", read_data, 32'h0);
    @(posedge clk);
    #1;
    check("abort sram9 untouched", 32'(mem[9]), 32'h0);
    check("abort sram8 lo", 32'(mem[8]), 32'h0000_F00D);
    rst = 1'b1;
    @(negedge clk);
    check("release ready", 32'(ready), 32'd1);
    check("release we_n", 32'(SRAM_WE_N), 32'd1);
    @(posedge clk);
    #1;

    access("rd1028 after rst", 1'b0, 1'b1, 32'd1028, 32'h0, 0, 1'b0);
    access("rd1032", 1'b0, 1'b1, 32'd1032, 32'h0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
